// File: rtl/sdram_host_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_host_bridge_if
//  Purpose  : Bundles the host request channel, the host response channel and
//             the controller command/status signals of sdram_host_bridge.
//  Modports : slave  - the bridge (consumes host requests, drives controller)
//             master - the environment (host plus sdram_controller side)
//  Signals  : host_valid/host_ready/host_rw/host_addr/host_wdata  request
//             rsp_valid/rsp_ready/rsp_rdata                       response
//             ctl_req/ctl_rw/ctl_addr/ctl_data_in                 to controller
//             ctl_data_out/ctl_busy                               from controller
//  Revision : 1.0 - initial release
// ============================================================================
interface sdram_host_bridge_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              host_valid;
    logic              host_ready;
    logic              host_rw;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    logic              ctl_req;
    logic              ctl_rw;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_data_in;
    logic [DATA_W-1:0] ctl_data_out;
    logic              ctl_busy;

    modport slave (
        input  host_valid, host_rw, host_addr, host_wdata,
        output host_ready,
        output rsp_valid, rsp_rdata,
        input  rsp_ready,
        output ctl_req, ctl_rw, ctl_addr, ctl_data_in,
        input  ctl_data_out, ctl_busy
    );

    modport master (
        output host_valid, host_rw, host_addr, host_wdata,
        input  host_ready,
        input  rsp_valid, rsp_rdata,
        output rsp_ready,
        input  ctl_req, ctl_rw, ctl_addr, ctl_data_in,
        output ctl_data_out, ctl_busy
    );
endinterface
`default_nettype wire

// File: rtl/sdram_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_host_bridge
//  Purpose  : Host-side front end for sdram_controller. Buffers host requests
//             in a FIFO, issues them one at a time with addr/rw/data held
//             stable, infers completion from ctl_busy falling and returns
//             read data on a valid/ready response channel.
//  Ports    : clk, rst_n (async, active-low)
//             bus         sdram_host_bridge_if.slave (host req/rsp + ctl side)
//             fifo_level  entries currently queued
//             err_timeout sticky watchdog flag
//  Options  : SDRAM_BRIDGE_TIMEOUT_EN - builds the ISSUE/WAIT_DONE watchdog;
//             when undefined err_timeout is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_host_bridge #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    sdram_host_bridge_if.slave          bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_timeout
);
    localparam int             c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int             c_ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam logic [c_PTR_W:0] c_PTR_ONE = (c_PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    // ---------------------------------------------------------------- FIFO --
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    // Extra MSB on each pointer is the wrap bit separating full from empty.
    logic [c_PTR_W:0]     r_wr_ptr;
    logic [c_PTR_W:0]     r_rd_ptr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;

    // ----------------------------------------------------------------- FSM --
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_req_set;
    logic                 w_req_clr;
    logic                 w_rsp_load;
    logic                 w_rsp_clr;

    // ------------------------------------------------- controller / host regs
    logic                 r_ctl_req;
    logic                 r_ctl_rw;
    logic [ADDR_W-1:0]    r_ctl_addr;
    logic [DATA_W-1:0]    r_ctl_data;
    logic                 r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    logic [c_WD_W-1:0]    r_wd_cnt;
    logic                 r_err;
    logic                 w_wd_expire;
    logic                 w_to_fire;
    logic                 w_rsp_zero;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    // host_ready depends only on full, so a pop in the same cycle never
    // opens a slot for the push.
    assign w_push     = bus.host_valid && !w_full;
    assign fifo_level = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {bus.host_rw, bus.host_addr, bus.host_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // ------------------------------------------------------- FSM register --
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ----------------------------------------------- FSM next state/actions
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_req_set   = 1'b0;
        w_req_clr   = 1'b0;
        w_rsp_load  = 1'b0;
        w_rsp_clr   = 1'b0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        w_to_fire   = 1'b0;
        w_rsp_zero  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !bus.ctl_busy) begin
                    w_pop       = 1'b1;
                    w_req_set   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // The controller acknowledges by raising busy; drop req then.
                if (bus.ctl_busy) begin
                    w_req_clr   = 1'b1;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.ctl_busy) begin
                    if (r_ctl_rw) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_rsp_load  = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RESP: begin
                // rsp_valid is always high in this state.
                if (bus.rsp_ready) begin
                    w_rsp_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        // Watchdog only acts when the normal exit has not happened this cycle.
        if ((r_state == S_ISSUE || r_state == S_WAIT_DONE) &&
            (w_state_nxt == r_state) && w_wd_expire) begin
            w_to_fire = 1'b1;
            w_req_clr = 1'b1;
            if (r_ctl_rw) begin
                w_state_nxt = S_IDLE;
            end else begin
                // Return a zero read so the host is never left waiting.
                w_rsp_zero  = 1'b1;
                w_state_nxt = S_RESP;
            end
        end
`endif
    end

    // ---------------------------------------- controller and response regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl_req   <= 1'b0;
            r_ctl_rw    <= 1'b0;
            r_ctl_addr  <= '0;
            r_ctl_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // Holding registers load only on a pop, so they stay constant
            // from ISSUE until the transaction completes.
            if (w_pop) begin
                {r_ctl_rw, r_ctl_addr, r_ctl_data} <= r_mem[r_rd_ptr[c_PTR_W-1:0]];
            end
            if (w_req_set)      r_ctl_req <= 1'b1;
            else if (w_req_clr) r_ctl_req <= 1'b0;

            if (w_rsp_load) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= bus.ctl_data_out;
            end
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
            else if (w_rsp_zero) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= '0;
            end
`endif
            else if (w_rsp_clr) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    assign w_wd_expire = (r_wd_cnt == c_WD_LAST);

    // Counter restarts on every state change and only runs while a command
    // is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_wd_cnt <= '0;
            end else if (r_state == S_ISSUE || r_state == S_WAIT_DONE) begin
                r_wd_cnt <= r_wd_cnt + c_WD_ONE;
            end
            if (w_to_fire) r_err <= 1'b1;
        end
    end

    assign err_timeout = r_err;
`else
    // Constant 0 for any legal TIMEOUT_CYCLES when the watchdog is not built.
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign bus.host_ready  = !w_full;
    assign bus.ctl_req     = r_ctl_req;
    assign bus.ctl_rw      = r_ctl_rw;
    assign bus.ctl_addr    = r_ctl_addr;
    assign bus.ctl_data_in = r_ctl_data;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sdram_host_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_host_bridge
//  Purpose  : Self-checking bench for sdram_host_bridge with a behavioural
//             sdram_controller model and request/response scoreboards.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_host_bridge;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [LVL_W-1:0] fifo_level;
    logic             err_timeout;

    sdram_host_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_host_bridge #(
        .FIFO_DEPTH    (DEPTH),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .fifo_level (fifo_level),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    req_t              req_q[$];
    logic [DATA_W-1:0] rsp_q[$];
    logic [DATA_W-1:0] shadow    [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];

    // controller model controls
    logic force_busy = 1'b0;
    logic stick      = 1'b0;
    int   lat        = 3;
    int   m_cnt      = 0;
    req_t m_cur;
    req_t m_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] shadow_rd(input logic [ADDR_W-1:0] a);
        return shadow.exists(a) ? shadow[a] : {8'h5A, a};
    endfunction

    function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : {8'h5A, a};
    endfunction

    // Expected controller command and (for reads) expected response data are
    // queued at the moment the host request is accepted.
    task automatic sb_record(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_t r;
        r.rw   = rw;
        r.addr = a;
        r.data = d;
        req_q.push_back(r);
        if (rw) shadow[a] = d;
        else    rsp_q.push_back(shadow_rd(a));
    endtask

    task automatic push(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        bus.host_valid = 1'b1;
        bus.host_rw    = rw;
        bus.host_addr  = a;
        bus.host_wdata = d;
        while (!bus.host_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.host_ready) begin
            check("push_ready_timeout", 64'(bus.host_ready), 64'(1));
        end else begin
            @(posedge clk); #1;
            sb_record(rw, a, d);
        end
        bus.host_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((req_q.size() != 0 || rsp_q.size() != 0 || bus.ctl_busy || bus.ctl_req ||
                fifo_level != 0 || bus.rsp_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_level", 64'(fifo_level), 64'(0));
        check("idle_queues", 64'(req_q.size() + rsp_q.size()), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctl"}, 64'({bus.ctl_req, bus.ctl_rw, bus.ctl_addr, bus.ctl_data_in}), 64'(0));
        check({tag, "_rsp"}, 64'({bus.rsp_valid, bus.rsp_rdata}), 64'(0));
        check({tag, "_level"}, 64'(fifo_level), 64'(0));
        check({tag, "_err"}, 64'(err_timeout), 64'(0));
        check({tag, "_ready"}, 64'(bus.host_ready), 64'(1));
    endtask

    // ------------------------------------------------- controller model --
    initial begin
        bus.ctl_busy     = 1'b0;
        bus.ctl_data_out = 32'h0BAD0BAD;
        forever begin
            @(posedge clk); #2;
            if (!rst_n) begin
                bus.ctl_busy = 1'b0;
                m_cnt        = 0;
            end else if (force_busy) begin
                bus.ctl_busy = 1'b1;
            end else if (m_cnt > 0) begin
                check("ctl_hold", 64'({bus.ctl_rw, bus.ctl_addr, bus.ctl_data_in}), 64'(m_cur));
                if (!stick) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        bus.ctl_busy = 1'b0;
                        if (!m_cur.rw) bus.ctl_data_out = model_rd(m_cur.addr);
                    end
                end
            end else if (bus.ctl_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 64'(bus.ctl_req), 64'(0));
                end else begin
                    m_exp = req_q.pop_front();
                    check("req_order", 64'({bus.ctl_rw, bus.ctl_addr, bus.ctl_data_in}), 64'(m_exp));
                end
                m_cur = {bus.ctl_rw, bus.ctl_addr, bus.ctl_data_in};
                if (m_cur.rw) model_mem[m_cur.addr] = m_cur.data;
                bus.ctl_busy = 1'b1;
                m_cnt        = lat;
            end else begin
                bus.ctl_busy = 1'b0;
            end
        end
    end

    // ---------------------------------------------- response scoreboard --
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) check("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
                else                   check("rsp_data", 64'(bus.rsp_rdata), 64'(rsp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    // ------------------------------------------------ directed sequence --
    initial begin
        int   n;
        logic last_valid;

        bus.host_valid = 1'b0;
        bus.host_rw    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.rsp_ready  = 1'b1;
        shadow[24'h000400]    = 32'hCAFEF00D;
        model_mem[24'h000400] = 32'hCAFEF00D;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single write: req two cycles after the push
        push(1'b1, 24'h012345, 32'hDEADBEEF);
        check("t1_req_early", 64'(bus.ctl_req), 64'(0));
        check("t1_level", 64'(fifo_level), 64'(1));
        @(posedge clk); #1;
        check("t1_req", 64'(bus.ctl_req), 64'(1));
        check("t1_ctl", 64'({bus.ctl_rw, bus.ctl_addr, bus.ctl_data_in}),
              64'({1'b1, 24'h012345, 32'hDEADBEEF}));
        check("t1_level_popped", 64'(fifo_level), 64'(0));
        wait_idle();

        // read with back-pressured response
        bus.rsp_ready = 1'b0;
        push(1'b0, 24'h000400, 32'h0);
        n = 0;
        while (!bus.ctl_busy && n < 50) begin @(posedge clk); #1; n++; end
        last_valid = bus.rsp_valid;
        while (bus.ctl_busy && n < 100) begin
            last_valid = bus.rsp_valid;
            @(posedge clk); #1;
            n++;
        end
        check("t2_valid_while_busy", 64'(last_valid), 64'(0));
        check("t2_valid_after_fall", 64'(bus.rsp_valid), 64'(1));
        check("t2_rdata", 64'(bus.rsp_rdata), 64'(32'hCAFEF00D));
        push(1'b1, 24'h000500, 32'h11112222);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t2_hold", 64'({bus.ctl_req, bus.rsp_valid, bus.rsp_rdata}),
                  64'({1'b0, 1'b1, 32'hCAFEF00D}));
        end
        check("t2_queued", 64'(fifo_level), 64'(1));
        bus.rsp_ready = 1'b1;
        wait_idle();

        // fill to full with the controller busy
        force_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push(1'b1, 24'h000100, 32'hA0A0A0A0);
        push(1'b0, 24'h000100, 32'h0);
        push(1'b1, 24'h000104, 32'hA1A1A1A1);
        push(1'b0, 24'h012345, 32'h0);
        check("t3_full", 64'({bus.host_ready, fifo_level}), 64'({1'b0, 3'd4}));
        bus.host_valid = 1'b1;
        bus.host_rw    = 1'b1;
        bus.host_addr  = 24'h000108;
        bus.host_wdata = 32'hA2A2A2A2;
        repeat (2) begin
            @(posedge clk); #1;
            check("t3_full_hold", 64'({bus.host_ready, fifo_level}), 64'({1'b0, 3'd4}));
        end
        force_busy = 1'b0;
        n = 0;
        while (fifo_level == 4 && n < 20) begin @(posedge clk); #1; n++; end
        check("t3_pop_no_push", 64'(fifo_level), 64'(3));
        check("t3_ready", 64'(bus.host_ready), 64'(1));
        @(posedge clk); #1;
        check("t3_fifth_in", 64'(fifo_level), 64'(4));
        sb_record(1'b1, 24'h000108, 32'hA2A2A2A2);
        bus.host_valid = 1'b0;
        wait_idle();

        // simultaneous push and pop at level 2, then wrap traffic
        force_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push(1'b1, 24'h000200, 32'hB0B0B0B0);
        push(1'b0, 24'h000200, 32'h0);
        check("t4_level2", 64'(fifo_level), 64'(2));
        force_busy     = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_rw    = 1'b1;
        bus.host_addr  = 24'h000204;
        bus.host_wdata = 32'hB1B1B1B1;
        @(posedge clk); #1;
        check("t4_push_pop_level", 64'(fifo_level), 64'(2));
        sb_record(1'b1, 24'h000204, 32'hB1B1B1B1);
        bus.host_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push((i % 2) == 0, 24'h000300 + 24'(i / 2 * 4), 32'hC0000000 + 32'(i));
        end
        wait_idle();

        // reset during WAIT_DONE with three queued
        lat = 20;
        push(1'b0, 24'h000400, 32'h0);
        push(1'b0, 24'h000100, 32'h0);
        push(1'b0, 24'h000104, 32'h0);
        push(1'b0, 24'h000200, 32'h0);
        n = 0;
        while (!(bus.ctl_busy && !bus.ctl_req && fifo_level == 3) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_pre", 64'({bus.ctl_busy, bus.ctl_req, fifo_level}), 64'({1'b1, 1'b0, 3'd3}));
        rst_n = 1'b0;
        #1;
        check_reset_values("t5_rst");
        req_q.delete();
        rsp_q.delete();
        lat = 3;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t5_no_req", 64'({bus.ctl_req, fifo_level}), 64'(0));
        end
        push(1'b1, 24'h000600, 32'hD0D0D0D0);
        push(1'b0, 24'h000600, 32'h0);
        wait_idle();

        // controller stuck busy on a read
        stick = 1'b1;
        push(1'b0, 24'h000400, 32'h0);
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        rsp_q[rsp_q.size() - 1] = 32'h0;
        repeat (80) @(posedge clk);
        #1;
        check("t6_err", 64'(err_timeout), 64'(1));
        check("t6_idle", 64'({bus.ctl_req, bus.rsp_valid, fifo_level}), 64'(0));
        check("t6_rsp_done", 64'(rsp_q.size()), 64'(0));
`else
        repeat (80) @(posedge clk);
        #1;
        check("t6_err", 64'(err_timeout), 64'(0));
        check("t6_waiting", 64'({bus.ctl_req, bus.rsp_valid}), 64'(0));
        check("t6_rsp_pending", 64'(rsp_q.size()), 64'(1));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdram_host_bridge.md
Name: sdram_host_bridge

Overview:
Host-side front end that feeds sdram_controller. It accepts host requests on a valid/ready channel and buffers them in a small FIFO. It issues them to the controller one at a time, holding addr/rw/data stable for the whole transaction. It returns read data on a valid/ready response channel. The controller has no done strobe, so completion is inferred from ctl_busy returning low.

Parameters:
FIFO_DEPTH, 4, request FIFO entries; power of 2, >= 2
ADDR_W, 24, host/controller address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
host_valid  in  1  request valid
host_ready  out  1  request accepted when valid&&ready
host_rw  in  1  1=write, 0=read
host_addr  in  ADDR_W  request address
host_wdata  in  DATA_W  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  host accepts read data
rsp_rdata  out  DATA_W  read data
ctl_req  out  1  request to controller
ctl_rw  out  1  to controller rw
ctl_addr  out  ADDR_W  to controller addr
ctl_data_in  out  DATA_W  to controller data_in
ctl_data_out  in  DATA_W  from controller data_out
ctl_busy  in  1  from controller busy
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued
err_timeout  out  1  sticky watchdog flag (tied 0 when feature is compiled out)

Behaviour:
- Reset values of all registered outputs: ctl_req=0, ctl_rw=0, ctl_addr=0, ctl_data_in=0, rsp_valid=0, rsp_rdata=0, fifo_level=0, err_timeout=0. FIFO pointers are cleared.
- Reset mid-transaction: the FIFO and any pending response are discarded. The controller is reset by the same rst_n.
- FIFO:
  - host_ready = !full.
  - When full, no push occurs even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - Condition to leave: FIFO non-empty and ctl_busy==0.
  - Action: pop the head into ctl_rw/ctl_addr/ctl_data_in, then go to ISSUE.
- ISSUE:
  - ctl_req=1.
  - When ctl_busy==1 is sampled, set ctl_req=0 and go to WAIT_DONE.
  - ctl_req is held until ctl_busy is seen high.
- WAIT_DONE:
  - ctl_* outputs are held constant.
  - When ctl_busy==0: if read, capture ctl_data_out into rsp_rdata, set rsp_valid=1, and go to RESP. If write, go to IDLE.
- RESP:
  - rsp_valid and rsp_rdata are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
  - rsp_ready may be held high permanently; the transfer still completes in 1 cycle.
  - No new command is issued while a response is pending.
- ctl_* holding registers change only on a pop, so they are stable from ISSUE through completion.
- Latency with an idle bridge and controller:
  - Push at edge N; ctl_req is high in cycle N+2.
  - A read's rsp_valid rises the cycle after ctl_busy falls.
- Ordering is strict FIFO. At most one transaction is outstanding.

Optional Feature:
SDRAM_BRIDGE_TIMEOUT_EN
- Defined: a counter runs during ISSUE and WAIT_DONE and clears on each state entry.
  - If it reaches TIMEOUT_CYCLES, set err_timeout=1 (sticky until reset), drop ctl_req, and go to IDLE.
  - A read that times out returns rsp_rdata=0 with rsp_valid=1, so the host never hangs.
- Undefined: no counter is built; err_timeout is constant 0 and ISSUE/WAIT_DONE wait indefinitely.

Test Plan:
- Single write with addr=24'h012345, wdata=32'hDEADBEEF and a controller model → ctl_req high 2 cycles after the push. ctl_addr/ctl_data_in stay constant until ctl_busy falls. No rsp_valid.
- Read from addr=24'h000400, model returns 32'hCAFEF00D → rsp_valid rises 1 cycle after ctl_busy falls with rsp_rdata=32'hCAFEF00D. With rsp_ready=0 for 5 cycles, the response is held and no ctl_req occurs meanwhile.
- Push 5 requests back-to-back with FIFO_DEPTH=4 and the controller stalled → host_ready=0 after the 4th push, fifo_level=4. The 5th is accepted the cycle after the first pop. All 5 are issued in order.
- Push and pop in the same cycle at level 2 → level stays 2. Pointers wrap after 8 transactions with no loss and no duplication.
- Assert rst_n=0 during WAIT_DONE with 3 queued → all outputs return to reset values, fifo_level=0. After release, no ctl_req without a new push.
- With SDRAM_BRIDGE_TIMEOUT_EN and ctl_busy stuck at 1 on a read → after 64 cycles err_timeout=1, rsp_valid=1 with rsp_rdata=0, state returns to IDLE. Without the macro, err_timeout stays 0 and the bridge waits.
